async_in_monitor: RTL and testbench

//  Receive-side counterpart of the random-timing stimulus used in the latch/DFF labs.

---
 rtl/async_in_monitor_pkg.sv | 21 ++
 rtl/sync_chain.sv | 21 ++
 rtl/async_in_monitor.sv | 132 +++++++++++++
 tb/tb_async_in_monitor.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/async_in_monitor_pkg.sv
// async_in_monitor shared types: debounce state encoding
// and a width-aware saturating increment helper.
package async_in_monitor_pkg;

  typedef enum logic [1:0] {
    ST_LO     = 2'd0,
    ST_CHK_HI = 2'd1,
    ST_HI     = 2'd2,
    ST_CHK_LO = 2'd3
  } state_t;

  function automatic logic [31:0] sat_inc(
    input logic [31:0] v,
    input int unsigned w
  );
    logic [31:0] top;
    top = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
    return (v >= top) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/sync_chain.sv
// sync_chain: STAGES-deep flop chain bringing an async bit
// into the clock domain, async active-high reset.
module sync_chain #(
  parameter int STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) ff <= '0;
    else       ff <= {ff[STAGES-2:0], i_d};
  end

  assign o_q = ff[STAGES-1];

endmodule

// File: rtl/async_in_monitor.sv
// async_in_monitor: sync + debounce of an async input, edge pulses, counters.
// Optional glitch counter: define ASYNC_IN_MONITOR_GLITCH_CNT_EN.
module async_in_monitor
  import async_in_monitor_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CNT     = 4,
  parameter int BW_CNT      = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_d,
  input  logic              i_clr,
  output logic              o_q,
  output logic              o_rise,
  output logic              o_fall,
  output logic              o_busy,
  output logic [BW_CNT-1:0] o_cnt_rise,
  output logic [BW_CNT-1:0] o_cnt_fall
`ifdef ASYNC_IN_MONITOR_GLITCH_CNT_EN
  ,
  output logic [BW_CNT-1:0] o_cnt_glitch
`endif
);

  localparam int DW = (DEB_CNT > 2) ? $clog2(DEB_CNT) : 1;
  localparam logic [DW-1:0] DLAST = DW'(DEB_CNT - 1);
  localparam logic [DW-1:0] DONE  = DW'(1);

  logic s;
  state_t state, state_nx;
  logic [DW-1:0] dcnt, dcnt_nx;
  logic acc_rise, acc_fall;

  sync_chain #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .i_d  (i_d),
    .o_q  (s)
  );

  always_comb begin
    state_nx = state;
    dcnt_nx  = dcnt;
    acc_rise = 1'b0;
    acc_fall = 1'b0;
    unique case (state)
      ST_LO: if (s) begin
        state_nx = ST_CHK_HI;
        dcnt_nx  = DONE;
      end
      ST_CHK_HI: if (!s) begin
        state_nx = ST_LO;
      end else if (dcnt == DLAST) begin
        state_nx = ST_HI;
        acc_rise = 1'b1;
      end else begin
        dcnt_nx = dcnt + DONE;
      end
      ST_HI: if (!s) begin
        state_nx = ST_CHK_LO;
        dcnt_nx  = DONE;
      end
      ST_CHK_LO: if (s) begin
        state_nx = ST_HI;
      end else if (dcnt == DLAST) begin
        state_nx = ST_LO;
        acc_fall = 1'b1;
      end else begin
        dcnt_nx = dcnt + DONE;
      end
      default: state_nx = ST_LO;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state  <= ST_LO;
      dcnt   <= '0;
      o_q    <= 1'b0;
      o_rise <= 1'b0;
      o_fall <= 1'b0;
      o_busy <= 1'b0;
    end else begin
      state  <= state_nx;
      dcnt   <= dcnt_nx;
      o_rise <= acc_rise;
      o_fall <= acc_fall;
      o_busy <= (state_nx == ST_CHK_HI) ||
                (state_nx == ST_CHK_LO);
      if (acc_rise)      o_q <= 1'b1;
      else if (acc_fall) o_q <= 1'b0;
    end
  end

  // counters follow the registered pulses so a clear
  // in the pulse cycle drops that edge
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_cnt_rise <= '0;
      o_cnt_fall <= '0;
    end else if (i_clr) begin
      o_cnt_rise <= '0;
      o_cnt_fall <= '0;
    end else begin
      if (o_rise)
        o_cnt_rise <= BW_CNT'(sat_inc(32'(o_cnt_rise), BW_CNT));
      if (o_fall)
        o_cnt_fall <= BW_CNT'(sat_inc(32'(o_cnt_fall), BW_CNT));
    end
  end

`ifdef ASYNC_IN_MONITOR_GLITCH_CNT_EN
  logic glitch;

  assign glitch =
    (state == ST_CHK_HI && state_nx == ST_LO) ||
    (state == ST_CHK_LO && state_nx == ST_HI);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)
      o_cnt_glitch <= '0;
    else if (i_clr)
      o_cnt_glitch <= '0;
    else if (glitch)
      o_cnt_glitch <= BW_CNT'(sat_inc(32'(o_cnt_glitch), BW_CNT));
  end
`endif

endmodule

// File: tb/tb_async_in_monitor.sv
// tb_async_in_monitor: random-offset async stimulus checked
// every cycle against a run-length debounce model.
module tb_async_in_monitor;

  localparam int SS   = 2;
  localparam int DB   = 4;
  localparam int BW   = 8;
  localparam int MAXC = 255;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic d   = 1'b0;
  logic clr = 1'b0;
  logic q, rise, fall, busy;
  logic [BW-1:0] cr, cf;
`ifdef ASYNC_IN_MONITOR_GLITCH_CNT_EN
  logic [BW-1:0] cg;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  async_in_monitor #(
    .SYNC_STAGES(SS),
    .DEB_CNT    (DB),
    .BW_CNT     (BW)
  ) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_d       (d),
    .i_clr     (clr),
    .o_q       (q),
    .o_rise    (rise),
    .o_fall    (fall),
    .o_busy    (busy),
    .o_cnt_rise(cr),
    .o_cnt_fall(cf)
`ifdef ASYNC_IN_MONITOR_GLITCH_CNT_EN
    ,
    .o_cnt_glitch(cg)
`endif
  );

  // hist: input samples not yet visible to the debouncer
  // run: consecutive visible samples disagreeing with q
  typedef struct {
    bit [SS-1:0] hist;
    bit q;
    int run;
    bit rise;
    bit fall;
    int cr;
    int cf;
    int cg;
  } model_t;

  model_t m;

  function automatic int sat(input int v);
    return (v < MAXC) ? v + 1 : v;
  endfunction

  function automatic model_t mreset();
    model_t r;
    r.hist = '0;
    r.q    = 1'b0;
    r.run  = 0;
    r.rise = 1'b0;
    r.fall = 1'b0;
    r.cr   = 0;
    r.cf   = 0;
    r.cg   = 0;
    return r;
  endfunction

  function automatic model_t step(
    input model_t o,
    input bit din,
    input bit cl
  );
    model_t n;
    bit obs;
    n      = o;
    obs    = o.hist[SS-1];
    n.hist = {o.hist[SS-2:0], din};
    n.rise = 1'b0;
    n.fall = 1'b0;
    if (obs != o.q) begin
      n.run = o.run + 1;
      if (n.run == DB) begin
        n.q    = obs;
        n.run  = 0;
        n.rise = obs;
        n.fall = !obs;
      end
    end else begin
      if (o.run > 0 && !cl) n.cg = sat(o.cg);
      n.run = 0;
    end
    if (cl) begin
      n.cr = 0;
      n.cf = 0;
      n.cg = 0;
    end else begin
      if (o.rise) n.cr = sat(o.cr);
      if (o.fall) n.cf = sat(o.cf);
    end
    return n;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) m <= mreset();
    else     m <= step(m, d, clr);
  end

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("cmp_q",    int'(q),    int'(m.q));
    chk("cmp_rise", int'(rise), int'(m.rise));
    chk("cmp_fall", int'(fall), int'(m.fall));
    chk("cmp_busy", int'(busy), int'(m.run > 0));
    chk("cmp_cr",   int'(cr),   m.cr);
    chk("cmp_cf",   int'(cf),   m.cf);
`ifdef ASYNC_IN_MONITOR_GLITCH_CNT_EN
    chk("cmp_cg",   int'(cg),   m.cg);
`endif
  end

  task automatic off();
    #($urandom_range(2, 4));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_q",    int'(q),    0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_cr",   int'(cr),   0);
    off();
    rst = 1'b0;
    repeat (4) @(posedge clk);

    // clean rise: o_q on the 6th edge
    off();
    d = 1'b1;
    repeat (5) @(posedge clk);
    #1 chk("lat_q_e5", int'(q), 0);
    @(posedge clk);
    #1 chk("lat_q_e6", int'(q), 1);
    chk("lat_rise_e6", int'(rise), 1);
    @(posedge clk);
    #1 chk("lat_rise_e7", int'(rise), 0);
    chk("lat_cr", int'(cr), 1);
    repeat (8) @(posedge clk);
    off();
    d = 1'b0;
    repeat (10) @(posedge clk);

    // two-cycle glitch
    off();
    d = 1'b1;
    @(posedge clk);
    @(posedge clk);
    off();
    d = 1'b0;
    @(posedge clk);
    #1 chk("gl_busy", int'(busy), 1);
    repeat (8) @(posedge clk);
    #1 chk("gl_q", int'(q), 0);
    chk("gl_cr", int'(cr), 1);
`ifdef ASYNC_IN_MONITOR_GLITCH_CNT_EN
    chk("gl_cg", int'(cg), 1);
`endif

    // saturation
    repeat (300) begin
      off();
      d = 1'b1;
      repeat (5) @(posedge clk);
      off();
      d = 1'b0;
      repeat (5) @(posedge clk);
    end
    repeat (10) @(posedge clk);
    #1 chk("sat_cr", int'(cr), 255);
    chk("sat_cf", int'(cf), 255);
    off();
    clr = 1'b1;
    @(posedge clk);
    #1 chk("clr_cr", int'(cr), 0);
    chk("clr_cf", int'(cf), 0);
    off();
    clr = 1'b0;

    // random timing
    repeat (200) begin
      d   = 1'($urandom_range(0, 1));
      clr = ($urandom_range(0, 11) == 0);
      @(posedge clk);
      off();
      clr = 1'b0;
      repeat ($urandom_range(0, 6)) @(posedge clk);
      off();
    end
    d = 1'b0;
    repeat (12) @(posedge clk);

    // reset during qualification
    off();
    d = 1'b1;
    repeat (4) @(posedge clk);
    #2 chk("mid_busy", int'(busy), 1);
    #1 rst = 1'b1;
    #1 chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_q",  int'(q),  0);
    chk("mid_rst_cr", int'(cr), 0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    repeat (5) @(posedge clk);
    #1 chk("req_q_e5", int'(q), 0);
    chk("req_rise_e5", int'(rise), 0);
    @(posedge clk);
    #1 chk("req_rise_e6", int'(rise), 1);
    repeat (4) @(posedge clk);

    // clear coincident with a fall pulse
    off();
    d = 1'b0;
    repeat (6) @(posedge clk);
    #1 chk("cf_fall", int'(fall), 1);
    #1 clr = 1'b1;
    @(posedge clk);
    #1 chk("cf_cnt", int'(cf), 0);
    chk("cf_cr", int'(cr), 0);
    chk("cf_fall_done", int'(fall), 0);
    #1 clr = 1'b0;
    repeat (5) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
